// File: rtl/regfile_seq_pkg.sv
// Shared types and constants for the operand read sequencer.
package regfile_seq_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned PC_ADDR    = 15;
  localparam int unsigned N_OPS      = 3;
  localparam int unsigned STATE_W    = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 3'd0,
    FETCH_A = 3'd1,
    FETCH_B = 3'd2,
    FETCH_C = 3'd3,
    DONE    = 3'd4
  } state_e;

endpackage

// File: rtl/regfile_seq_next_op.sv
// Picks the next FETCH state: lowest set mask bit above the current slot.
module regfile_seq_next_op
  import regfile_seq_pkg::*;
(
  input  logic [STATE_W-1:0] cur_state_i,
  input  logic [2:0]         mask_i,
  output logic [STATE_W-1:0] next_state_c_o
);

  logic [2:0] above;
  logic [2:0] remain;

  // Slots strictly above the one being fetched now (all of them from IDLE).
  always_comb begin
    above = 3'b000;
    case (cur_state_i)
      IDLE:    above = 3'b111;
      FETCH_A: above = 3'b110;
      FETCH_B: above = 3'b100;
      default: above = 3'b000;
    endcase
  end

  assign remain = mask_i & above;

  // Lowest remaining wanted operand wins; none left means DONE.
  always_comb begin
    next_state_c_o = DONE;
    if (remain[0])      next_state_c_o = FETCH_A;
    else if (remain[1]) next_state_c_o = FETCH_B;
    else if (remain[2]) next_state_c_o = FETCH_C;
  end

endmodule

// File: rtl/regfile_read_seq.sv
// Sequences up to three operand reads through one regfile read port.
// Address 15 returns pc_value instead of the regfile.
// Optional: define REGFILE_READ_SEQ_BYPASS_EN to forward snooped writebacks.
module regfile_read_seq
  import regfile_seq_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr_a,
  input  logic [ADDR_W-1:0] req_addr_b,
  input  logic [ADDR_W-1:0] req_addr_c,
  input  logic [2:0]        req_mask,
  input  logic [DATA_W-1:0] pc_value,
  output logic [ADDR_W-1:0] rf_r_addr,
  input  logic [DATA_W-1:0] rf_r_data,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [DATA_W-1:0] op_c
);

  state_e                         state_q, state_d;
  logic [2:0]                     mask_q, mask_d;
  logic [N_OPS-1:0][ADDR_W-1:0]   addr_q, addr_d;
  logic [N_OPS-1:0][DATA_W-1:0]   op_q, op_d;
  logic                           req_ready_q;
  logic                           op_valid_q;
  logic [ADDR_W-1:0]              rf_addr_q, rf_addr_d;
  logic [2:0]                     pick_mask;
  logic [STATE_W-1:0]             next_fetch;
  logic [1:0]                     cur_idx;
  logic [ADDR_W-1:0]              cur_addr;
  logic [DATA_W-1:0]              fetch_data;
  logic [N_OPS-1:0]               wb_hit;

  function automatic logic is_pc(input logic [ADDR_W-1:0] a);
    return a == ADDR_W'(PC_ADDR);
  endfunction

  assign pick_mask = (state_q == IDLE) ? req_mask : mask_q;

  regfile_seq_next_op u_next_op (
    .cur_state_i    (state_q),
    .mask_i         (pick_mask),
    .next_state_c_o (next_fetch)
  );

  // Which slot the current FETCH state reads, and its latched address.
  always_comb begin
    cur_idx  = 2'd0;
    cur_addr = '0;
    case (state_q)
      FETCH_A: begin cur_idx = 2'd0; cur_addr = addr_q[0]; end
      FETCH_B: begin cur_idx = 2'd1; cur_addr = addr_q[1]; end
      FETCH_C: begin cur_idx = 2'd2; cur_addr = addr_q[2]; end
      default: begin cur_idx = 2'd0; cur_addr = '0; end
    endcase
  end

`ifdef REGFILE_READ_SEQ_BYPASS_EN
  logic [N_OPS-1:0] capt_q, capt_d;

  // Writeback forwarding: newest value for the slot being fetched and for captured slots.
  always_comb begin
    fetch_data = is_pc(cur_addr) ? pc_value : rf_r_data;
    if (wb_en && (wb_addr == cur_addr) && !is_pc(cur_addr)) fetch_data = wb_data;
    wb_hit = '0;
    for (int i = 0; i < N_OPS; i++) begin
      wb_hit[i] = capt_q[i] && wb_en && (wb_addr == addr_q[i]) && !is_pc(addr_q[i]);
    end
  end

  // Tracks which operands have already been fetched for this request.
  always_comb begin
    capt_d = capt_q;
    if (state_q == IDLE && req_valid) begin
      capt_d = '0;
    end else if (state_q == FETCH_A || state_q == FETCH_B || state_q == FETCH_C) begin
      for (int i = 0; i < N_OPS; i++) begin
        if (2'(i) == cur_idx) capt_d[i] = 1'b1;
      end
    end
  end

  // Captured-operand flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) capt_q <= '0;
    else        capt_q <= capt_d;
  end
`else
  logic unused_wb;

  // Writeback snoop is ignored; PC substitution only.
  always_comb begin
    fetch_data = is_pc(cur_addr) ? pc_value : rf_r_data;
    wb_hit     = '0;
  end

  assign unused_wb = ^{wb_en, wb_addr, wb_data};
`endif

  // Next-state and datapath updates for the sequencer.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    addr_d  = addr_q;
    op_d    = op_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          mask_d  = req_mask;
          addr_d  = {req_addr_c, req_addr_b, req_addr_a};
          op_d    = '0;
          state_d = state_e'(next_fetch);
        end
      end
      FETCH_A, FETCH_B, FETCH_C: begin
        for (int i = 0; i < N_OPS; i++) begin
          if (wb_hit[i]) op_d[i] = wb_data;
          if (2'(i) == cur_idx) op_d[i] = fetch_data;
        end
        state_d = state_e'(next_fetch);
      end
      DONE: begin
        for (int i = 0; i < N_OPS; i++) begin
          if (wb_hit[i]) op_d[i] = wb_data;
        end
        if (op_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Read-port address for the upcoming state; PC slots never touch the regfile.
  always_comb begin
    rf_addr_d = '0;
    case (state_d)
      FETCH_A: rf_addr_d = is_pc(addr_d[0]) ? '0 : addr_d[0];
      FETCH_B: rf_addr_d = is_pc(addr_d[1]) ? '0 : addr_d[1];
      FETCH_C: rf_addr_d = is_pc(addr_d[2]) ? '0 : addr_d[2];
      default: rf_addr_d = '0;
    endcase
  end

  // State, latched request and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mask_q      <= '0;
      addr_q      <= '0;
      op_q        <= '0;
      req_ready_q <= 1'b1;
      op_valid_q  <= 1'b0;
      rf_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      addr_q      <= addr_d;
      op_q        <= op_d;
      req_ready_q <= (state_d == IDLE);
      op_valid_q  <= (state_d == DONE);
      rf_addr_q   <= rf_addr_d;
    end
  end

  assign req_ready = req_ready_q;
  assign op_valid  = op_valid_q;
  assign rf_r_addr = rf_addr_q;
  assign op_a      = op_q[0];
  assign op_b      = op_q[1];
  assign op_c      = op_q[2];

endmodule

// File: tb/tb_regfile_read_seq.sv
// Bench for regfile_read_seq: directed cases plus randomized requests against a
// transaction-level model. Honours REGFILE_READ_SEQ_BYPASS_EN when defined.
module tb_regfile_read_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_addr_a, req_addr_b, req_addr_c;
  logic [2:0]  req_mask;
  logic [31:0] pc_value;
  logic [3:0]  rf_r_addr;
  logic [31:0] rf_r_data;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic        op_valid;
  logic        op_ready;
  logic [31:0] op_a, op_b, op_c;

  logic [31:0] rf [16];
  logic [3:0]  rd_seq [16];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  assign rf_r_data = rf[rf_r_addr];

  regfile_read_seq #(.DATA_W(32), .ADDR_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr_a (req_addr_a),
    .req_addr_b (req_addr_b),
    .req_addr_c (req_addr_c),
    .req_mask   (req_mask),
    .pc_value   (pc_value),
    .rf_r_addr  (rf_r_addr),
    .rf_r_data  (rf_r_data),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_a       (op_a),
    .op_b       (op_b),
    .op_c       (op_c)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: phase 0 idle, 1 fetching list[n], 2 results held.
  initial begin : model
    int          m_phase;
    int          m_n;
    int          m_k;
    int          m_list [3];
    logic [3:0]  m_addr [3];
    logic [31:0] m_op [3];
    bit          m_capt [3];
    logic [3:0]  a;
    logic [31:0] v;
    logic [3:0]  exp_rd;
    int          idx;
    m_phase = 0; m_n = 0; m_k = 0;
    for (int i = 0; i < 3; i++) begin
      m_list[i] = 0; m_addr[i] = '0; m_op[i] = '0; m_capt[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_phase = 0; m_n = 0; m_k = 0;
        for (int i = 0; i < 3; i++) begin
          m_addr[i] = '0; m_op[i] = '0; m_capt[i] = 1'b0;
        end
      end
      exp_rd = 4'd0;
      if (m_phase == 1) begin
        a = m_addr[m_list[m_n]];
        exp_rd = (a == 4'd15) ? 4'd0 : a;
      end
      check("req_ready", 32'(req_ready), 32'(m_phase == 0));
      check("op_valid", 32'(op_valid), 32'(m_phase == 2));
      check("rf_r_addr", 32'(rf_r_addr), 32'(exp_rd));
      check("op_a", op_a, m_op[0]);
      check("op_b", op_b, m_op[1]);
      check("op_c", op_c, m_op[2]);
      if (rst_n) begin
`ifdef REGFILE_READ_SEQ_BYPASS_EN
        if (m_phase != 0) begin
          for (int i = 0; i < 3; i++) begin
            if (m_capt[i] && wb_en && wb_addr == m_addr[i] && m_addr[i] != 4'd15) m_op[i] = wb_data;
          end
        end
`endif
        case (m_phase)
          0: if (req_valid) begin
            m_addr[0] = req_addr_a; m_addr[1] = req_addr_b; m_addr[2] = req_addr_c;
            m_k = 0;
            for (int i = 0; i < 3; i++) begin
              m_op[i] = '0; m_capt[i] = 1'b0;
              if (req_mask[i]) begin m_list[m_k] = i; m_k++; end
            end
            m_n = 0;
            m_phase = (m_k == 0) ? 2 : 1;
          end
          1: begin
            idx = m_list[m_n];
            a = m_addr[idx];
            v = (a == 4'd15) ? pc_value : rf[a];
`ifdef REGFILE_READ_SEQ_BYPASS_EN
            if (wb_en && wb_addr == a && a != 4'd15) v = wb_data;
`endif
            m_op[idx] = v;
            m_capt[idx] = 1'b1;
            m_n++;
            if (m_n == m_k) m_phase = 2;
          end
          default: if (op_ready) m_phase = 0;
        endcase
      end
    end
  end

  task automatic noise();
    pc_value = $urandom;
    wb_en    = ($urandom_range(0, 2) == 0);
    wb_addr  = ($urandom_range(0, 1) == 1) ? req_addr_a : 4'($urandom_range(0, 15));
    wb_data  = $urandom;
  endtask

  // Issue one request, wait for op_valid; lat = negedges from accept edge to op_valid seen.
  task automatic run_req(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                         input logic [2:0] m, input bit rnd, input int wb_cyc,
                         input logic [3:0] wb_a, input logic [31:0] wb_d, output int lat);
    int guard;
    @(posedge clk); #1;
    req_addr_a = a; req_addr_b = b; req_addr_c = c; req_mask = m; req_valid = 1'b1;
    guard = 0;
    do begin @(negedge clk); guard++; end while (!req_ready && guard < 20);
    check("accept", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (rnd) noise();
    lat = 0;
    for (int i = 0; i < 16; i++) rd_seq[i] = 4'hx;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      rd_seq[lat] = rf_r_addr;
      if (op_valid) break;
      @(posedge clk); #1;
      if (rnd) noise();
      if (lat == wb_cyc) begin wb_en = 1'b1; wb_addr = wb_a; wb_data = wb_d; end
      else if (lat == wb_cyc + 1) wb_en = 1'b0;
    end
    check("op_valid_seen", 32'(op_valid), 32'd1);
  endtask

  task automatic release_ops(input int hold, input bit rnd);
    repeat (hold) begin @(posedge clk); #1; if (rnd) noise(); end
    @(posedge clk); #1;
    op_ready = 1'b1;
    if (rnd) noise();
    @(posedge clk); #1;
    op_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int          lat;
    logic [3:0]  a, b, c;
    logic [2:0]  m;
    rst_n = 1'b0; req_valid = 1'b0; req_addr_a = '0; req_addr_b = '0; req_addr_c = '0;
    req_mask = '0; pc_value = '0; wb_en = 1'b0; wb_addr = '0; wb_data = '0; op_ready = 1'b0;
    for (int i = 0; i < 16; i++) rf[i] = 32'h1000 + 32'(i);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_req_ready", 32'(req_ready), 32'd1);
    check("reset_op_valid", 32'(op_valid), 32'd0);

    // Three operands from the regfile.
    rf[1] = 32'h11; rf[2] = 32'h22; rf[3] = 32'h33;
    run_req(4'd1, 4'd2, 4'd3, 3'b111, 1'b0, -1, 4'd0, 32'd0, lat);
    check("t1_latency", 32'(lat), 32'd4);
    check("t1_rd1", 32'(rd_seq[1]), 32'd1);
    check("t1_rd2", 32'(rd_seq[2]), 32'd2);
    check("t1_rd3", 32'(rd_seq[3]), 32'd3);
    check("t1_op_a", op_a, 32'h11);
    check("t1_op_b", op_b, 32'h22);
    check("t1_op_c", op_c, 32'h33);
    release_ops(0, 1'b0);

    // PC substitution with a skipped middle operand.
    pc_value = 32'h108; rf[4] = 32'hAB; rf[15] = 32'hBAD0BAD0;
    run_req(4'd15, 4'd7, 4'd4, 3'b101, 1'b0, -1, 4'd0, 32'd0, lat);
    check("t2_latency", 32'(lat), 32'd3);
    check("t2_rd1", 32'(rd_seq[1]), 32'd0);
    check("t2_rd2", 32'(rd_seq[2]), 32'd4);
    check("t2_op_a", op_a, 32'h108);
    check("t2_op_b", op_b, 32'h0);
    check("t2_op_c", op_c, 32'hAB);
    release_ops(0, 1'b0);

    // Empty mask, results held while op_ready stays low.
    run_req(4'd9, 4'd10, 4'd11, 3'b000, 1'b0, -1, 4'd0, 32'd0, lat);
    check("t3_latency", 32'(lat), 32'd1);
    repeat (5) begin
      @(negedge clk);
      check("t3_hold_valid", 32'(op_valid), 32'd1);
      check("t3_hold_ready", 32'(req_ready), 32'd0);
      check("t3_hold_ops", op_a | op_b | op_c, 32'd0);
    end
    release_ops(0, 1'b0);

    // Writeback to a's register while b is being fetched.
    rf[5] = 32'h5555; rf[6] = 32'h6666;
    run_req(4'd5, 4'd6, 4'd0, 3'b011, 1'b0, 1, 4'd5, 32'hDEAD, lat);
    check("t4_latency", 32'(lat), 32'd3);
`ifdef REGFILE_READ_SEQ_BYPASS_EN
    check("t4_op_a", op_a, 32'hDEAD);
`else
    check("t4_op_a", op_a, 32'h5555);
`endif
    check("t4_op_b", op_b, 32'h6666);
    release_ops(0, 1'b0);

    // Reset in the middle of FETCH_B aborts the request.
    @(posedge clk); #1;
    req_addr_a = 4'd1; req_addr_b = 4'd2; req_addr_c = 4'd3; req_mask = 3'b111; req_valid = 1'b1;
    @(negedge clk);
    check("t5_accept", 32'(req_ready), 32'd1);
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #3 rst_n = 1'b0;
    @(negedge clk);
    check("t5_rst_valid", 32'(op_valid), 32'd0);
    check("t5_rst_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("t5_post_valid", 32'(op_valid), 32'd0);
      check("t5_post_ready", 32'(req_ready), 32'd1);
    end
    run_req(4'd1, 4'd2, 4'd3, 3'b111, 1'b0, -1, 4'd0, 32'd0, lat);
    check("t5_latency", 32'(lat), 32'd4);
    check("t5_op_c", op_c, 32'h33);
    release_ops(0, 1'b0);

    // Randomized requests with writeback and PC noise.
    for (int t = 0; t < 200; t++) begin
      repeat ($urandom_range(0, 3)) rf[$urandom_range(0, 15)] = $urandom;
      a = 4'($urandom_range(0, 15));
      b = ($urandom_range(0, 3) == 0) ? a : 4'($urandom_range(0, 15));
      c = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
      m = 3'($urandom_range(0, 7));
      run_req(a, b, c, m, 1'b1, -1, 4'd0, 32'd0, lat);
      check("rand_latency", 32'(lat), 32'($countones(m) + 1));
      release_ops($urandom_range(0, 3), 1'b1);
    end
    wb_en = 1'b0;
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
